// File: rtl/cpu_mem_responder.sv
// Memory-side slave for the 16-bit CPU bus: accepts one request, inserts WAIT wait states, then a one-cycle ack.
// Optional macro MEM_RANGE_CHECK_EN: accesses with addr >= DEPTH are suppressed and flagged on err.
module cpu_mem_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int WAIT   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam bit                HAS_WAIT = (WAIT > 0);
    localparam logic [3:0]        WAIT_LD  = HAS_WAIT ? 4'(WAIT - 1) : 4'd0;
    localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                access_s;
    logic                acc_we_s;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [DATA_W-1:0]   acc_wdata_s;
    logic [IDX_W-1:0]    acc_idx_s;
    logic                oor_s;
    logic                mem_wr_s;

    logic [DATA_W-1:0]   mem_q [DEPTH];

`ifdef MEM_RANGE_CHECK_EN
    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return (a >> IDX_W) != {ADDR_W{1'b0}};
    endfunction
`endif

    // Request sequencing: accept, wait-state countdown, access strobe and busy tracking.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        access_s    = 1'b0;
        acc_we_s    = we_q;
        acc_addr_s  = addr_q;
        acc_wdata_s = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    busy_d  = 1'b1;
                    if (HAS_WAIT) begin
                        cnt_d   = WAIT_LD;
                        state_d = ST_WAIT;
                    end else begin
                        // Zero wait states: the access happens on the accept edge itself.
                        access_s    = 1'b1;
                        acc_we_s    = we;
                        acc_addr_s  = addr;
                        acc_wdata_s = wdata;
                        state_d     = ST_ACK;
                    end
                end else if (ack_q) begin
                    busy_d = 1'b0;
                end else begin
                    busy_d = busy_q;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    access_s = 1'b1;
                    state_d  = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Access datapath: RAM index aliasing, range check, read data capture and ack/err strobes.
    always_comb begin
        acc_idx_s = IDX_W'(acc_addr_s & IDX_MASK);
`ifdef MEM_RANGE_CHECK_EN
        oor_s = out_of_range(acc_addr_s);
        err_d = (state_q == ST_ACK) && out_of_range(addr_q);
`else
        oor_s = 1'b0;
        err_d = 1'b0;
`endif
        mem_wr_s = access_s & acc_we_s & ~oor_s;
        if (access_s && !acc_we_s) begin
            rdata_d = oor_s ? {DATA_W{1'b0}} : mem_q[acc_idx_s];
        end else begin
            rdata_d = rdata_q;
        end
        ack_d = (state_q == ST_ACK);
    end

    // Control and output registers; asynchronous reset aborts any access not yet performed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            ack_q   <= 1'b0;
            rdata_q <= {DATA_W{1'b0}};
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Word RAM: contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_wr_s) begin
            mem_q[acc_idx_s] <= acc_wdata_s;
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule
